// File: rtl/iomem_interconnect.sv
// iomem_interconnect
//   N-slave router for the picosoc iomem bus. addr[31:24] is decoded against a
//   per-slave base table. A matching slave gets a one-hot s_valid until it
//   answers or the access times out. The status base is served internally.
//   Anything else is answered at once with ERR_RDATA. The response to the core
//   is always a registered, single-cycle iomem_ready with iomem_rdata.
//
// Ports
//   clk, resetn              clock, synchronous active-low reset
//   iomem_valid/ready        core request / one-cycle response strobe
//   iomem_wstrb/addr/wdata   core request payload (wstrb == 0 means read)
//   iomem_rdata              read data, zero whenever iomem_ready is low
//   s_valid[NUM_SLAVES]      one-hot slave request
//   s_ready[NUM_SLAVES]      slave completion, only the selected bit is used
//   s_wstrb/addr/wdata       combinational broadcast of the core payload
//   s_rdata[32*NUM_SLAVES]   slave i read data on bits [32i+31:32i]
//   bus_err_irq              one-cycle pulse per slave timeout
module iomem_interconnect #(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [8*NUM_SLAVES-1:0] SLAVE_BASE = {8'h07, 8'h05, 8'h04, 8'h03},
    parameter logic [7:0]  STATUS_BASE    = 8'h0F,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     iomem_valid,
    output logic                     iomem_ready,
    input  logic [3:0]               iomem_wstrb,
    input  logic [31:0]              iomem_addr,
    input  logic [31:0]              iomem_wdata,
    output logic [31:0]              iomem_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    output logic [3:0]               s_wstrb,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic                     bus_err_irq
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [15:0]        tcnt;
    logic [15:0]        tcount;
    logic               timeout_sticky;
    logic               unmapped_sticky;
    logic [31:0]        err_addr;

    logic               status_hit;
    logic               slave_hit;
    logic [SEL_W-1:0]   hit_idx;
    logic [31:0]        stat_rdata;
    logic               sel_ready;
    logic [31:0]        sel_rdata;

    assign s_wstrb = iomem_wstrb;
    assign s_addr  = iomem_addr;
    assign s_wdata = iomem_wdata;

    // Scan from the top index down so the lowest matching slave wins when
    // several table entries share a base.
    always_comb begin
        status_hit = (iomem_addr[31:24] == STATUS_BASE);
        slave_hit  = 1'b0;
        hit_idx    = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (iomem_addr[31:24] == SLAVE_BASE[8*i +: 8]) begin
                slave_hit = 1'b1;
                hit_idx   = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        stat_rdata = '0;
        case (iomem_addr[7:0])
            8'h00:   stat_rdata = {tcount, 14'b0, unmapped_sticky, timeout_sticky};
            8'h04:   stat_rdata = err_addr;
            default: stat_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            iomem_ready     <= 1'b0;
            iomem_rdata     <= '0;
            s_valid         <= '0;
            bus_err_irq     <= 1'b0;
            sel             <= '0;
            tcnt            <= '0;
            tcount          <= '0;
            timeout_sticky  <= 1'b0;
            unmapped_sticky <= 1'b0;
            err_addr        <= '0;
        end else begin
            iomem_ready <= 1'b0;
            bus_err_irq <= 1'b0;
            case (state)
                IDLE: begin
                    if (iomem_valid) begin
                        if (status_hit) begin
                            if (iomem_wstrb != 4'b0) begin
                                iomem_rdata <= '0;
                                if (iomem_addr[7:0] == 8'h00) begin
                                    tcount          <= '0;
                                    timeout_sticky  <= 1'b0;
                                    unmapped_sticky <= 1'b0;
                                end
                            end else begin
                                iomem_rdata <= stat_rdata;
                            end
                            iomem_ready <= 1'b1;
                            state       <= RESP;
                        end else if (slave_hit) begin
                            sel     <= hit_idx;
                            s_valid <= NUM_SLAVES'(1) << hit_idx;
                            tcnt    <= '0;
                            state   <= ACCESS;
                        end else begin
                            unmapped_sticky <= 1'b1;
                            err_addr        <= iomem_addr;
                            iomem_rdata     <= ERR_RDATA;
                            iomem_ready     <= 1'b1;
                            state           <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // A slave answering on the last allowed cycle still wins.
                    if (sel_ready) begin
                        s_valid     <= '0;
                        iomem_rdata <= sel_rdata;
                        iomem_ready <= 1'b1;
                        state       <= RESP;
                    end else if (tcnt == TCNT_LAST) begin
                        s_valid        <= '0;
                        iomem_rdata    <= ERR_RDATA;
                        timeout_sticky <= 1'b1;
                        err_addr       <= iomem_addr;
                        if (tcount != 16'hFFFF) tcount <= tcount + 16'd1;
                        bus_err_irq    <= 1'b1;
                        iomem_ready    <= 1'b1;
                        state          <= RESP;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                RESP: begin
                    // Spend one cycle here so IDLE never re-samples the
                    // request that was just answered.
                    iomem_rdata <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_interconnect.sv
module tb_iomem_interconnect;

    logic         clk = 1'b0;
    logic         resetn;
    logic         iomem_valid;
    logic [3:0]   iomem_wstrb;
    logic [31:0]  iomem_addr;
    logic [31:0]  iomem_wdata;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;

    logic         iomem_ready, bus_err_irq;
    logic [31:0]  iomem_rdata, s_addr, s_wdata;
    logic [3:0]   s_valid, s_wstrb;

    logic         iomem_ready2, bus_err_irq2;
    logic [31:0]  iomem_rdata2, s_addr2, s_wdata2;
    logic [3:0]   s_valid2, s_wstrb2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    iomem_interconnect #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .bus_err_irq(bus_err_irq)
    );

    // Duplicate base: slaves 0 and 3 both decode 0x03.
    iomem_interconnect #(.TIMEOUT_CYCLES(8),
                         .SLAVE_BASE({8'h03, 8'h05, 8'h04, 8'h03})) dut2 (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready2),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata2),
        .s_valid(s_valid2), .s_ready(s_ready), .s_wstrb(s_wstrb2),
        .s_addr(s_addr2), .s_wdata(s_wdata2), .s_rdata(s_rdata),
        .bus_err_irq(bus_err_irq2)
    );

    // dly: wait cycles before the slave raises s_ready (-1 = never).
    // Slave i returns sdata + i, so rd also proves which slot was selected.
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] sdata;
        int          dly;
        logic [3:0]  sv;
        int          lat;
        logic [31:0] rd;
        int          vc;
        int          irq;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string nm);
        int vc, irqs, bad, lat;
        logic [31:0] rd;
        bit done;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = v.addr;
        iomem_wstrb = v.wstrb;
        iomem_wdata = v.wdata;
        for (int i = 0; i < 4; i++) s_rdata[32*i +: 32] = v.sdata + 32'(i);
        s_ready = 4'b0;
        vc = 0; irqs = 0; bad = 0; lat = -1; rd = 32'hx; done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_err_irq) irqs++;
            if (s_valid != 4'b0) begin
                vc++;
                if (s_valid !== v.sv || s_addr !== v.addr ||
                    s_wdata !== v.wdata || s_wstrb !== v.wstrb) bad++;
                s_ready = (vc - 1 == v.dly) ? v.sv : 4'b0;
            end else begin
                s_ready = 4'b0;
            end
            if (iomem_ready) begin
                lat = c; rd = iomem_rdata; done = 1'b1;
                iomem_valid = 1'b0; s_ready = 4'b0;
            end else if (iomem_rdata !== 32'h0) begin
                bad++;
            end
        end
        if (!done) iomem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (bus_err_irq) irqs++;
        chk({nm, " latency"}, 32'(lat), 32'(v.lat));
        chk({nm, " rdata"}, rd, v.rd);
        chk({nm, " s_valid cycles"}, 32'(vc), 32'(v.vc));
        chk({nm, " slave bus/idle rdata errors"}, 32'(bad), 32'd0);
        chk({nm, " irq pulses"}, 32'(irqs), 32'(v.irq));
        chk({nm, " ready single pulse"}, {31'b0, iomem_ready}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //            addr          wstrb  wdata          sdata         dly sv      lat rd             vc irq
        tbl[0]  = '{32'h0F00_0000, 4'h0, 32'h0,        32'h0,         -1, 4'b0000, 1, 32'h0,         0, 0};
        tbl[1]  = '{32'h0F00_0004, 4'h0, 32'h0,        32'h0,         -1, 4'b0000, 1, 32'h0,         0, 0};
        tbl[2]  = '{32'h0300_0010, 4'h0, 32'h0,        32'h1234_5678,  0, 4'b0001, 2, 32'h1234_5678, 1, 0};
        tbl[3]  = '{32'h0500_0000, 4'hF, 32'hA5,       32'hDEAD_0000,  3, 4'b0100, 5, 32'hDEAD_0002, 4, 0};
        tbl[4]  = '{32'h0400_0000, 4'h0, 32'h0,        32'h5555_0000, -1, 4'b0010, 9, 32'h0,         8, 1};
        tbl[5]  = '{32'h0F00_0000, 4'h0, 32'h0,        32'h0,         -1, 4'b0000, 1, 32'h0001_0001, 0, 0};
        tbl[6]  = '{32'h0F00_0004, 4'h0, 32'h0,        32'h0,         -1, 4'b0000, 1, 32'h0400_0000, 0, 0};
        tbl[7]  = '{32'h0900_0000, 4'h0, 32'h0,        32'h7777_0000, -1, 4'b0000, 1, 32'h0,         0, 0};
        tbl[8]  = '{32'h0F00_0000, 4'h0, 32'h0,        32'h0,         -1, 4'b0000, 1, 32'h0001_0003, 0, 0};
        tbl[9]  = '{32'h0F00_0004, 4'h0, 32'h0,        32'h0,         -1, 4'b0000, 1, 32'h0900_0000, 0, 0};
        tbl[10] = '{32'h0F00_0000, 4'hF, 32'hFFFF_FFFF, 32'h0,        -1, 4'b0000, 1, 32'h0,         0, 0};
        tbl[11] = '{32'h0F00_0000, 4'h0, 32'h0,        32'h0,         -1, 4'b0000, 1, 32'h0,         0, 0};
        tbl[12] = '{32'h0F00_0008, 4'h0, 32'h0,        32'h0,         -1, 4'b0000, 1, 32'h0,         0, 0};
        tbl[13] = '{32'h0700_0000, 4'h0, 32'h0,        32'hCAFE_0000,  1, 4'b1000, 3, 32'hCAFE_0003, 2, 0};
        tbl[14] = '{32'h0700_0004, 4'h0, 32'h0,        32'hBEEF_0000, -1, 4'b1000, 9, 32'h0,         8, 1};
        tbl[15] = '{32'h0F00_0004, 4'hF, 32'h1234,     32'h0,         -1, 4'b0000, 1, 32'h0,         0, 0};
        tbl[16] = '{32'h0F00_0004, 4'h0, 32'h0,        32'h0,         -1, 4'b0000, 1, 32'h0700_0004, 0, 0};
        tbl[17] = '{32'h0F00_0000, 4'h0, 32'h0,        32'h0,         -1, 4'b0000, 1, 32'h0001_0001, 0, 0};
        tbl[18] = '{32'h0F00_0000, 4'h1, 32'h0,        32'h0,         -1, 4'b0000, 1, 32'h0,         0, 0};
        tbl[19] = '{32'h0F00_0000, 4'h0, 32'h0,        32'h0,         -1, 4'b0000, 1, 32'h0,         0, 0};

        resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        iomem_addr = 32'h0; iomem_wdata = 32'h0; s_ready = 4'h0; s_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset iomem_ready", {31'b0, iomem_ready}, 32'd0);
        chk("reset s_valid", {28'b0, s_valid}, 32'd0);
        chk("reset irq", {31'b0, bus_err_irq}, 32'd0);
        chk("reset rdata", iomem_rdata, 32'h0);
        resetn = 1'b1;

        for (int k = 0; k < 20; k++) run(tbl[k], $sformatf("vec%0d", k));

        // Reset during ACCESS abandons the transaction.
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = 32'h0300_0000; iomem_wstrb = 4'h0; s_ready = 4'h0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("midreset s_valid before", {28'b0, s_valid}, 32'h1);
        resetn = 1'b0; iomem_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midreset s_valid after", {28'b0, s_valid}, 32'h0);
        chk("midreset iomem_ready", {31'b0, iomem_ready}, 32'd0);
        resetn = 1'b1;
        run('{32'h0F00_0000, 4'h0, 32'h0, 32'h0, -1, 4'b0000, 1, 32'h0, 0, 0}, "post-reset status0");
        run('{32'h0F00_0004, 4'h0, 32'h0, 32'h0, -1, 4'b0000, 1, 32'h0, 0, 0}, "post-reset status4");
        run('{32'h0400_0000, 4'h0, 32'h0, 32'h55AA_0000, 2, 4'b0010, 4, 32'h55AA_0001, 3, 0}, "post-reset read");

        // Duplicate base: lowest index wins, s_ready of the other slave ignored.
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = 32'h0300_0040; iomem_wstrb = 4'h0; s_ready = 4'h0;
        for (int i = 0; i < 4; i++) s_rdata[32*i +: 32] = 32'h1111_0000 + 32'(i);
        @(posedge clk); @(negedge clk);
        chk("dup s_valid c1", {28'b0, s_valid2}, 32'h1);
        s_ready = 4'b1000;
        @(posedge clk); @(negedge clk);
        chk("dup s_valid c2", {28'b0, s_valid2}, 32'h1);
        chk("dup ready ignored", {31'b0, iomem_ready2}, 32'd0);
        s_ready = 4'b0001;
        @(posedge clk); @(negedge clk);
        chk("dup iomem_ready", {31'b0, iomem_ready2}, 32'd1);
        chk("dup rdata", iomem_rdata2, 32'h1111_0000);
        chk("dup s_addr", s_addr2, 32'h0300_0040);
        chk("dup irq", {31'b0, bus_err_irq2}, 32'd0);
        iomem_valid = 1'b0; s_ready = 4'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
